serial_comp: RTL and testbench

Bit-serial magnitude comparator for two WIDTH-bit unsigned operands that arrive one bit per accepted cycle on a pair of serial lines. It is the sequential counterpart of the single-bit equality cell: it consumes framed x/y bit streams, MSB-first by default, and reports greater/equal/less once per frame. It sits between a serial source, such as a shift-register front end or the bench driver, and any logic that needs an ordering decision.

---
 rtl/serial_comp_pkg.sv | 28 ++
 rtl/serial_comp_bit_cmp1.sv | 10 +
 rtl/serial_comp.sv | 115 +++++++++++
 tb/tb_serial_comp.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_comp_pkg.sv
// Shared types for the bit-serial comparator: FSM states, the 2-bit decision
// encoding and its mapping onto the gt/eq/lt flags.
package serial_comp_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_flags_t;

    function automatic cmp_flags_t cmp_decode(input logic [1:0] code);
        cmp_flags_t f;
        f.gt = (code == CMP_GT);
        f.eq = (code == CMP_EQ);
        f.lt = (code == CMP_LT);
        return f;
    endfunction

endpackage

// File: rtl/serial_comp_bit_cmp1.sv
// Combinational 1-bit magnitude cell: flags which operand bit is the larger.
module bit_cmp1 (
    input  logic x,
    input  logic y,
    output logic bgt,
    output logic blt
);
    assign bgt = x & ~y;
    assign blt = ~x & y;
endmodule

// File: rtl/serial_comp.sv
// Bit-serial WIDTH-bit unsigned comparator reporting gt/eq/lt once per frame.
// Define SERIAL_COMP_LSB_FIRST_EN for LSB-first operand order (default MSB-first).
module serial_comp
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic x,
    input  logic y,
    output logic busy,
    output logic done,
    output logic gt,
    output logic eq,
    output logic lt
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [1:0]      dec_reg, dec_next;
    logic [1:0]      dec_upd;
    cmp_flags_t      res_reg, res_next;
    logic            done_reg, done_next;
    logic            bgt, blt;

    bit_cmp1 u_bit_cmp1 (
        .x   (x),
        .y   (y),
        .bgt (bgt),
        .blt (blt)
    );

    // Decision after folding in the current bit.
    always_comb begin
        dec_upd = dec_reg;
`ifdef SERIAL_COMP_LSB_FIRST_EN
        // Later bits are more significant, so every difference overwrites.
        if (bgt)
            dec_upd = CMP_GT;
        else if (blt)
            dec_upd = CMP_LT;
`else
        // The first difference seen is the most significant one; lock it.
        if (dec_reg == CMP_EQ) begin
            if (bgt)
                dec_upd = CMP_GT;
            else if (blt)
                dec_upd = CMP_LT;
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dec_next   = dec_reg;
        res_next   = res_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    dec_next   = CMP_EQ;
                end
            end
            SHIFT: begin
                // A restart wins over a simultaneous final bit.
                if (start) begin
                    cnt_next = '0;
                    dec_next = CMP_EQ;
                end else if (bit_valid) begin
                    dec_next = dec_upd;
                    if (cnt_reg == LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        res_next   = cmp_decode(dec_upd);
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dec_reg   <= CMP_EQ;
            res_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dec_reg   <= dec_next;
            res_reg   <= res_next;
            done_reg  <= done_next;
        end
    end

    assign busy = (state_reg == SHIFT);
    assign done = done_reg;
    assign gt   = res_reg.gt;
    assign eq   = res_reg.eq;
    assign lt   = res_reg.lt;

endmodule

// File: tb/tb_serial_comp.sv
// Directed, table-driven bench for serial_comp (WIDTH=8); follows the bit
// order of the build via SERIAL_COMP_LSB_FIRST_EN.
module tb_serial_comp;
    localparam int WIDTH = 8;
    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    logic clk = 1'b0;
    logic rst, start, bit_valid, x, y;
    logic busy, done, gt, eq, lt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] xv;
        logic [7:0] yv;
        int         stall;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[8];

    serial_comp #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bit_idx(input int i);
`ifdef SERIAL_COMP_LSB_FIRST_EN
        return i;
`else
        return WIDTH - 1 - i;
`endif
    endfunction

    // Called at a negedge with the DUT already in SHIFT; ends at the negedge
    // right after the final bit edge, where done must be high.
    task automatic send_bits(input logic [7:0] xv, input logic [7:0] yv,
                             input int stall, input logic [2:0] exp, input string tag);
        int early = 0;
        int not_busy = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == 4 && stall > 0) begin
                bit_valid = 1'b0;
                repeat (stall) begin
                    @(negedge clk);
                    if (done) early++;
                    if (!busy) not_busy++;
                end
            end
            bit_valid = 1'b1;
            x = xv[bit_idx(i)];
            y = yv[bit_idx(i)];
            @(negedge clk);
            if (i < WIDTH - 1) begin
                if (done) early++;
                if (!busy) not_busy++;
            end
        end
        bit_valid = 1'b0;
        chk({tag, "_early_done"}, early, 0);
        chk({tag, "_busy_drop"}, not_busy, 0);
        chk({tag, "_done"}, {31'd0, done}, 1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        chk({tag, "_flags"}, {29'd0, gt, eq, lt}, {29'd0, exp});
        $display("frame %s x=%02h y=%02h stall=%0d -> gt=%b eq=%b lt=%b done=%b",
                 tag, xv, yv, stall, gt, eq, lt, done);
    endtask

    task automatic run_frame(input logic [7:0] xv, input logic [7:0] yv,
                             input int stall, input logic [2:0] exp, input string tag);
        start     = 1'b1;
        bit_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_after_start"}, {31'd0, busy}, 1);
        chk({tag, "_done_after_start"}, {31'd0, done}, 0);
        send_bits(xv, yv, stall, exp, tag);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 0, R_EQ};
        vecs[1] = '{8'h80, 8'h7F, 0, R_GT};
        vecs[2] = '{8'h3C, 8'h3D, 3, R_LT};
        vecs[3] = '{8'hFF, 8'hFE, 0, R_GT};
        vecs[4] = '{8'h00, 8'h00, 0, R_EQ};
        vecs[5] = '{8'h01, 8'h00, 0, R_GT};
        vecs[6] = '{8'h00, 8'hFF, 0, R_LT};
        vecs[7] = '{8'h7F, 8'h80, 0, R_LT};

        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; x = 1'b0; y = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        rst = 1'b0;

        // Idle with bit_valid toggling: nothing may happen.
        for (int c = 0; c < 5; c++) begin
            bit_valid = ~bit_valid;
            x = 1'($urandom_range(0, 1));
            y = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        end
        bit_valid = 1'b0;
        $display("idle 5 cycles busy=%b done=%b", busy, done);

        // Back-to-back frames: each start lands in the previous done cycle.
        for (int v = 0; v < 8; v++)
            run_frame(vecs[v].xv, vecs[v].yv, vecs[v].stall, vecs[v].exp,
                      $sformatf("vec%0d", v));
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("flags_hold_idle", {29'd0, gt, eq, lt}, {29'd0, R_LT});

        // Abort after 5 bits, then a complete frame.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1; x = 1'b1; y = 1'b0;
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 0);
        end
        bit_valid = 1'b0;
        chk("abort_flags_held", {29'd0, gt, eq, lt}, {29'd0, R_LT});
        $display("abort after 5 bits gt=%b eq=%b lt=%b", gt, eq, lt);
        run_frame(8'h01, 8'h00, 0, R_GT, "restart");

        // Restart coinciding with the final bit: start wins, no done.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bit_valid = 1'b1; x = 1'b0; y = 1'b1;
            @(negedge clk);
        end
        start = 1'b1; bit_valid = 1'b1; x = 1'b0; y = 1'b1;
        @(negedge clk);
        start = 1'b0; bit_valid = 1'b0;
        chk("prio_no_done", {31'd0, done}, 0);
        chk("prio_busy", {31'd0, busy}, 1);
        chk("prio_flags_held", {29'd0, gt, eq, lt}, {29'd0, R_GT});
        $display("start over final bit done=%b busy=%b", done, busy);
        send_bits(8'h55, 8'h55, 0, R_EQ, "after_prio");

        // Asynchronous reset mid-frame.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; x = 1'b0; y = 1'b1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        $display("reset mid-frame busy=%b gt=%b eq=%b lt=%b", busy, gt, eq, lt);
        @(negedge clk);
        rst = 1'b0;
        run_frame(8'h00, 8'hFF, 0, R_LT, "post_reset");

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
